// File: rtl/board_frame_renderer.sv
// -----------------------------------------------------------------------------
// board_frame_renderer
//
// Renders a square board of BOARD_DIM x BOARD_DIM cells into a virtual
// framebuffer, one pixel per clock, through a simple address/data/strobe
// write port. Each start request scans the full framebuffer once in raster
// order. Board contents and cursor are snapshotted at start, so the game
// logic may keep changing its inputs while a frame is being drawn.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      one-cycle render request (ignored unless idle)
//   board      packed cell status, cell (x,y) at [(y*BOARD_DIM+x)*CELL_BITS +: CELL_BITS]
//   cursor_x   cursor column (values >= BOARD_DIM give no highlight)
//   cursor_y   cursor row
//   cursor_en  enable the cursor outline
//   fb_addr    framebuffer write address (py*FB_WIDTH+px)
//   fb_data    RGB888 pixel data
//   fb_we      write strobe, one pixel per asserted cycle
//   busy       high while pixels are being written
//   done       one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module board_frame_renderer #(
   parameter int BOARD_DIM   = 8,
   parameter int CELL_BITS   = 3,
   parameter int SQUARE_PX   = 15,
   parameter int FB_WIDTH    = 160,
   parameter int FB_HEIGHT   = 120,
   parameter int X_OFFSET    = 20,
   parameter int Y_OFFSET    = 0,
   parameter int PIECE_INSET = 3,
   parameter int ADDR_W      = 15
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [BOARD_DIM*BOARD_DIM*CELL_BITS-1:0] board,
   input  logic [3:0]                               cursor_x,
   input  logic [3:0]                               cursor_y,
   input  logic                                     cursor_en,
   output logic [ADDR_W-1:0]                        fb_addr,
   output logic [23:0]                              fb_data,
   output logic                                     fb_we,
   output logic                                     busy,
   output logic                                     done
);

   localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * CELL_BITS;
   localparam int BOARD_PX   = BOARD_DIM * SQUARE_PX;
   localparam int PXW        = $clog2(FB_WIDTH + 1);
   localparam int PYW        = $clog2(FB_HEIGHT + 1);
   localparam int OW         = $clog2(SQUARE_PX + 1);
   localparam int IW         = $clog2(BOARD_BITS);

   localparam logic [PXW-1:0] PX_LAST    = PXW'(FB_WIDTH - 1);
   localparam logic [PYW-1:0] PY_LAST    = PYW'(FB_HEIGHT - 1);
   localparam logic [PXW-1:0] X_LO       = PXW'(X_OFFSET);
   localparam logic [PYW-1:0] Y_LO       = PYW'(Y_OFFSET);
   localparam logic [PXW-1:0] X_SPAN     = PXW'(BOARD_PX);
   localparam logic [PYW-1:0] Y_SPAN     = PYW'(BOARD_PX);
   localparam logic [PXW-1:0] X_TAIL     = PXW'(FB_WIDTH - X_OFFSET);
   localparam logic [PYW-1:0] Y_TAIL     = PYW'(FB_HEIGHT - Y_OFFSET);
   localparam logic [OW-1:0]  OFF_LAST   = OW'(SQUARE_PX - 1);
   localparam logic [OW-1:0]  INSET      = OW'(PIECE_INSET);
   localparam logic [OW-1:0]  PIECE_SPAN = OW'(SQUARE_PX - 2 * PIECE_INSET);

   localparam logic [23:0] COL_BG     = 24'h000040;
   localparam logic [23:0] COL_CURSOR = 24'hFFFF00;
   localparam logic [23:0] COL_LIGHT  = 24'hF0D9B5;
   localparam logic [23:0] COL_DARK   = 24'hB58863;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAW   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [PXW-1:0]          px_q, px_d, cx_q, cx_d;
   logic [PYW-1:0]          py_q, py_d, cy_q, cy_d;
   logic [OW-1:0]           ox_q, ox_d, oy_q, oy_d;
   logic [BOARD_BITS-1:0]   snap_board_q, snap_board_d;
   logic [3:0]              snap_cx_q, snap_cx_d, snap_cy_q, snap_cy_d;
   logic                    snap_cen_q, snap_cen_d;
   logic [ADDR_W-1:0]       fb_addr_q, fb_addr_d;
   logic [23:0]             fb_data_q, fb_data_d;
   logic                    fb_we_q, fb_we_d, busy_q, busy_d, done_q, done_d;

   logic [PXW-1:0]          px_rel_s, px_rel_n_s;
   logic [PYW-1:0]          py_rel_s, py_rel_n_s;
   logic                    x_started_s, y_started_s;
   logic [OW-1:0]           ox_rel_s, oy_rel_s;
   logic                    in_board_s, on_edge_s, cur_hit_s, in_piece_s;
   logic [IW-1:0]           bit_base_s;
   logic [CELL_BITS-1:0]    status_s;
   logic [23:0]             colour_s;

   function automatic logic [23:0] piece_colour(input logic [CELL_BITS-1:0] st);
      logic [23:0] c;
      case (st)
         CELL_BITS'(1): c = 24'hFF0000;
         CELL_BITS'(2): c = 24'h202020;
         CELL_BITS'(3): c = 24'hFF8080;
         CELL_BITS'(4): c = 24'h808080;
         default:       c = 24'hFF00FF;   // illegal status marker
      endcase
      return c;
   endfunction

   // Unsigned wrap-around trick: (p - LO) < SPAN is true exactly for LO <= p < LO+SPAN,
   // because values below LO wrap to a number larger than any legal span.
   assign px_rel_s    = px_q - X_LO;
   assign py_rel_s    = py_q - Y_LO;
   assign x_started_s = (px_rel_s < X_TAIL);
   assign y_started_s = (py_rel_s < Y_TAIL);

   // FSM next state, raster/cell counters, snapshot and registered-output controls
   always_comb begin
      state_d      = state_q;
      px_d         = px_q;
      py_d         = py_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      ox_d         = ox_q;
      oy_d         = oy_q;
      snap_board_d = snap_board_q;
      snap_cx_d    = snap_cx_q;
      snap_cy_d    = snap_cy_q;
      snap_cen_d   = snap_cen_q;
      fb_addr_d    = fb_addr_q;
      fb_we_d      = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_board_d = board;
               snap_cx_d    = cursor_x;
               snap_cy_d    = cursor_y;
               snap_cen_d   = cursor_en;
               px_d         = '0;
               py_d         = '0;
               cx_d         = '0;
               cy_d         = '0;
               ox_d         = '0;
               oy_d         = '0;
               fb_addr_d    = '0;
               fb_we_d      = 1'b1;
               busy_d       = 1'b1;
               state_d      = S_DRAW;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DRAW: begin
            if ((px_q == PX_LAST) && (py_q == PY_LAST)) begin
               done_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               fb_we_d   = 1'b1;
               busy_d    = 1'b1;
               fb_addr_d = fb_addr_q + ADDR_W'(1);
               if (px_q == PX_LAST) begin
                  px_d = '0;
                  cx_d = '0;
                  ox_d = '0;
                  py_d = py_q + PYW'(1);
                  // Cell row counters only run once the raster is at or below the board top.
                  if (y_started_s) begin
                     if (oy_q == OFF_LAST) begin
                        oy_d = '0;
                        cy_d = cy_q + PYW'(1);
                     end else begin
                        oy_d = oy_q + OW'(1);
                     end
                  end else begin
                     oy_d = oy_q;
                  end
               end else begin
                  px_d = px_q + PXW'(1);
                  if (x_started_s) begin
                     if (ox_q == OFF_LAST) begin
                        ox_d = '0;
                        cx_d = cx_q + PXW'(1);
                     end else begin
                        ox_d = ox_q + OW'(1);
                     end
                  end else begin
                     ox_d = ox_q;
                  end
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Colour of the pixel about to be presented, from next-state counters and snapshot
   always_comb begin
      px_rel_n_s = px_d - X_LO;
      py_rel_n_s = py_d - Y_LO;
      in_board_s = (px_rel_n_s < X_SPAN) && (py_rel_n_s < Y_SPAN);
      on_edge_s  = (ox_d == '0) || (ox_d == OFF_LAST) || (oy_d == '0) || (oy_d == OFF_LAST);
      cur_hit_s  = snap_cen_d && (cx_d == PXW'(snap_cx_d)) && (cy_d == PYW'(snap_cy_d));
      ox_rel_s   = ox_d - INSET;
      oy_rel_s   = oy_d - INSET;
      in_piece_s = (ox_rel_s < PIECE_SPAN) && (oy_rel_s < PIECE_SPAN);
      if (in_board_s) begin
         bit_base_s = IW'((32'(cy_d) * BOARD_DIM + 32'(cx_d)) * CELL_BITS);
      end else begin
         bit_base_s = '0;
      end
      status_s = snap_board_d[bit_base_s +: CELL_BITS];
      if (!in_board_s) begin
         colour_s = COL_BG;
      end else if (cur_hit_s && on_edge_s) begin
         colour_s = COL_CURSOR;
      end else if ((status_s != '0) && in_piece_s) begin
         colour_s = piece_colour(status_s);
      end else if ((cx_d[0] ^ cy_d[0]) == 1'b0) begin
         colour_s = COL_LIGHT;
      end else begin
         colour_s = COL_DARK;
      end
   end

   // Pixel data register loads only when a write is being presented
   always_comb begin
      if (fb_we_d) begin
         fb_data_d = colour_s;
      end else begin
         fb_data_d = fb_data_q;
      end
   end

   // State, counters, snapshot and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         px_q         <= '0;
         py_q         <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         ox_q         <= '0;
         oy_q         <= '0;
         snap_board_q <= '0;
         snap_cx_q    <= '0;
         snap_cy_q    <= '0;
         snap_cen_q   <= 1'b0;
         fb_addr_q    <= '0;
         fb_data_q    <= '0;
         fb_we_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         px_q         <= px_d;
         py_q         <= py_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         ox_q         <= ox_d;
         oy_q         <= oy_d;
         snap_board_q <= snap_board_d;
         snap_cx_q    <= snap_cx_d;
         snap_cy_q    <= snap_cy_d;
         snap_cen_q   <= snap_cen_d;
         fb_addr_q    <= fb_addr_d;
         fb_data_q    <= fb_data_d;
         fb_we_q      <= fb_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign fb_addr = fb_addr_q;
   assign fb_data = fb_data_q;
   assign fb_we   = fb_we_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_board_frame_renderer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for board_frame_renderer. A behavioural model computes
// each pixel colour straight from the rendering rules (division/modulo on
// pixel coordinates, snapshot kept by the bench) and every presented write is
// compared against it; a few hand-computed pixels pin the model.
// -----------------------------------------------------------------------------
module tb_board_frame_renderer;

   localparam int BD   = 8;
   localparam int CB   = 3;
   localparam int SQ   = 15;
   localparam int FW   = 160;
   localparam int FH   = 120;
   localparam int XO   = 20;
   localparam int YO   = 0;
   localparam int PI   = 3;
   localparam int AW   = 15;
   localparam int NPIX = FW * FH;
   localparam int BB   = BD * BD * CB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [BB-1:0] board;
   logic [3:0]    cursor_x;
   logic [3:0]    cursor_y;
   logic          cursor_en;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_data;
   logic          fb_we;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   board_frame_renderer #(
      .BOARD_DIM(BD), .CELL_BITS(CB), .SQUARE_PX(SQ), .FB_WIDTH(FW), .FB_HEIGHT(FH),
      .X_OFFSET(XO), .Y_OFFSET(YO), .PIECE_INSET(PI), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .board(board),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .busy(busy), .done(done)
   );

   int            errors = 0;
   int            checks = 0;
   logic [BB-1:0] m_board;
   int            m_cux, m_cuy;
   logic          m_cen;
   bit            chk_en = 1'b0;
   int            n_writes, n_dones, n_yellow;
   bit            last_we;
   int            last_addr;
   logic [23:0]   frame [NPIX];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference colour of pixel (px,py) for the current snapshot.
   function automatic logic [23:0] mcol(input int px, input int py);
      int cx, cy, ox, oy, st;
      if (px < XO || px >= XO + BD * SQ || py < YO || py >= YO + BD * SQ) return 24'h000040;
      cx = (px - XO) / SQ;
      ox = (px - XO) % SQ;
      cy = (py - YO) / SQ;
      oy = (py - YO) % SQ;
      st = int'(m_board[(cy * BD + cx) * CB +: CB]);
      if (m_cen && cx == m_cux && cy == m_cuy && (ox == 0 || ox == SQ - 1 || oy == 0 || oy == SQ - 1))
         return 24'hFFFF00;
      if (st != 0 && ox >= PI && ox <= SQ - 1 - PI && oy >= PI && oy <= SQ - 1 - PI) begin
         case (st)
            1:       return 24'hFF0000;
            2:       return 24'h202020;
            3:       return 24'hFF8080;
            4:       return 24'h808080;
            default: return 24'hFF00FF;
         endcase
      end
      return ((cx + cy) % 2 == 0) ? 24'hF0D9B5 : 24'hB58863;
   endfunction

   // One clock; sample on the falling edge and compare against the model.
   task automatic cycle();
      @(negedge clk);
      if (chk_en) begin
         check("busy_eq_we", 32'(busy), 32'(fb_we));
         if (fb_we) begin
            check("addr", 32'(fb_addr), 32'(n_writes));
            check("pixel", 32'(fb_data), 32'(mcol(n_writes % FW, n_writes / FW)));
            if (n_writes < NPIX) frame[n_writes] = fb_data;
            if (fb_data == 24'hFFFF00) n_yellow++;
            n_writes++;
         end
         if (done) begin
            n_dones++;
            check("done_after_last", last_we ? 32'(last_addr) : 32'hFFFFFFFF, 32'(NPIX - 1));
         end
         last_we   = fb_we;
         last_addr = int'(fb_addr);
      end
   endtask

   task automatic begin_render(input logic [BB-1:0] brd, input logic [3:0] cux,
                               input logic [3:0] cuy, input logic cen);
      board = brd; cursor_x = cux; cursor_y = cuy; cursor_en = cen; start = 1'b1;
      m_board = brd; m_cux = int'(cux); m_cuy = int'(cuy); m_cen = cen;
      n_writes = 0; n_dones = 0; n_yellow = 0; last_we = 1'b0; chk_en = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic render(input logic [BB-1:0] brd, input logic [3:0] cux, input logic [3:0] cuy,
                         input logic cen, input int restart_at, input logic [BB-1:0] alt_brd);
      begin_render(brd, cux, cuy, cen);
      for (int i = 0; i < NPIX + 20 && n_dones == 0; i++) begin
         if (i == restart_at) begin
            start = 1'b1; board = alt_brd; cursor_en = ~cen; cursor_x = 4'd0; cursor_y = 4'd0;
         end else begin
            start = 1'b0;
         end
         cycle();
      end
      start = 1'b0;
      check("render_timeout", 32'(n_dones != 0), 32'd1);
      cycle();
      cycle();
      check("write_count", 32'(n_writes), 32'(NPIX));
      check("done_count", 32'(n_dones), 32'd1);
      chk_en = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_we"},   32'(fb_we),   32'd0);
      check({tag, "_busy"}, 32'(busy),    32'd0);
      check({tag, "_done"}, 32'(done),    32'd0);
      check({tag, "_addr"}, 32'(fb_addr), 32'd0);
      check({tag, "_data"}, 32'(fb_data), 32'd0);
   endtask

   logic [BB-1:0] b_fix, b_rnd;

   initial begin
      rst = 1'b0; start = 1'b0; board = '0; cursor_x = 4'd0; cursor_y = 4'd0; cursor_en = 1'b0;
      repeat (3) cycle();
      check_quiet("reset");
      rst = 1'b1;
      repeat (4) cycle();
      check_quiet("idle");

      // Pin the model with hand-computed pixels.
      b_fix = '0;
      b_fix[2:0]   = 3'd6;   // cell (0,0): illegal status
      b_fix[59:57] = 3'd1;   // cell (3,2): status 1
      m_board = b_fix; m_cux = 3; m_cuy = 2; m_cen = 1'b0;
      check("model_bg",     32'(mcol(0, 0)),   32'h000040);
      check("model_piece",  32'(mcol(72, 37)), 32'hFF0000);
      check("model_magenta", 32'(mcol(29, 9)), 32'hFF00FF);

      // Fixed board, cursor disabled.
      render(b_fix, 4'd3, 4'd2, 1'b0, -1, '0);
      check("px0_bg",      32'(frame[0]),    32'h000040);
      check("px20_light",  32'(frame[20]),   32'hF0D9B5);
      check("px35_dark",   32'(frame[35]),   32'hB58863);
      check("px1469_mag",  32'(frame[1469]), 32'hFF00FF);
      check("px5992_red",  32'(frame[5992]), 32'hFF0000);
      check("px4865_sq",   32'(frame[4865]), 32'hB58863);
      check("no_cursor_yellow", 32'(n_yellow), 32'd0);

      // Same board with cursor (3,2); a restart and new inputs arrive mid-render.
      for (int k = 0; k < BB / 32; k++) b_rnd[k*32 +: 32] = $urandom();
      render(b_fix, 4'd3, 4'd2, 1'b1, 100, b_rnd);
      check("px4865_cursor", 32'(frame[4865]), 32'hFFFF00);
      check("px5992_red2",   32'(frame[5992]), 32'hFF0000);
      check("outline_count", 32'(n_yellow), 32'd56);

      // Random board, cursor column off the board.
      for (int k = 0; k < BB / 32; k++) b_rnd[k*32 +: 32] = $urandom();
      render(b_rnd, 4'd9, 4'($urandom_range(0, 7)), 1'b1, -1, '0);
      check("offboard_cursor_yellow", 32'(n_yellow), 32'd0);

      // Reset in the middle of a render.
      for (int k = 0; k < BB / 32; k++) b_rnd[k*32 +: 32] = $urandom();
      begin_render(b_rnd, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 1'b1);
      repeat (50) cycle();
      check("pre_abort_writes", 32'(n_writes), 32'd51);
      chk_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("abort_we",   32'(fb_we), 32'd0);
      check("abort_busy", 32'(busy),  32'd0);
      check("abort_done", 32'(done),  32'd0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("abort_hold_done", 32'(done), 32'd0);
      end
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("after_abort_we",   32'(fb_we), 32'd0);
         check("after_abort_done", 32'(done),  32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
